// File: rtl/counter_cmd_pkg.sv
// Shared definitions for the command-driven counter control block.
//   state_e       : command FSM states (IDLE / CLR / HOLD)
//   clog2_min1()  : ceil(log2(n)) clamped to at least 1 bit
//   mode_w()      : width of one channel's mode field
//   ch_w()        : width of the channel index
package counter_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_HOLD
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int mode_w(input int mode_n);
    return clog2_min1(mode_n);
  endfunction

  function automatic int ch_w(input int num_ch);
    return clog2_min1(num_ch);
  endfunction

endpackage

// File: rtl/counter_cmd_ch.sv
// One counter channel: run-enable flag and wrapping mode register.
//   clk, rst     : clock, asynchronous active-high reset
//   tgl_en_i     : toggle the run enable this cycle
//   adv_mode_i   : advance the mode this cycle (MODE_N-1 wraps to 0)
//   enable_o     : registered run enable
//   mode_o       : registered mode, always < MODE_N
module counter_cmd_ch
  import counter_cmd_pkg::*;
#(
  parameter int MODE_N = 3,
  localparam int MODE_W = mode_w(MODE_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgl_en_i,
  input  logic              adv_mode_i,
  output logic              enable_o,
  output logic [MODE_W-1:0] mode_o
);

  logic              en_q, en_d;
  logic [MODE_W-1:0] mode_q, mode_d;

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    if (tgl_en_i) begin
      en_d = ~en_q;
    end
    if (adv_mode_i) begin
      mode_d = (mode_q == MODE_W'(MODE_N - 1)) ? '0 : mode_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      mode_q <= '0;
    end else begin
      en_q   <= en_d;
      mode_q <= mode_d;
    end
  end

  assign enable_o = en_q;
  assign mode_o   = mode_q;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command controller for NUM_CH counter channels. A command accepted in IDLE
// toggles enables / advances modes of the targeted channels and optionally
// launches a CLR_CYC-cycle clear pulse, followed by one HOLD cycle.
//   clk, rst    : clock, asynchronous active-high reset
//   cmd_valid   : command offered;  cmd_ready : accepted only in IDLE
//   cmd_ch      : target channel;   cmd_bcast : target all channels
//   cmd_clear / cmd_enable / cmd_mode : request bits, applied together
//   o_enable    : per-channel run enable
//   o_mode      : per-channel mode, channel i at [i*MODE_W +: MODE_W]
//   o_clear     : per-channel clear pulse
//   o_err       : one-cycle pulse for a command naming a nonexistent channel
module counter_cmd_ctrl
  import counter_cmd_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MODE_N  = 3,
  parameter int CLR_CYC = 2,
  localparam int MODE_W = mode_w(MODE_N),
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic                     cmd_bcast,
  input  logic                     cmd_clear,
  input  logic                     cmd_enable,
  input  logic                     cmd_mode,
  output logic [NUM_CH-1:0]        o_enable,
  output logic [NUM_CH*MODE_W-1:0] o_mode,
  output logic [NUM_CH-1:0]        o_clear,
  output logic                     o_err
);

  localparam int CNT_W = clog2_min1(CLR_CYC);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  clr_q, clr_d;
  logic               err_q, err_d;

  logic [NUM_CH-1:0]  target;
  logic [NUM_CH-1:0]  tgl_en;
  logic [NUM_CH-1:0]  adv_mode;
  logic               accept;
  logic               any_req;
  logic               bad_ch;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign any_req   = cmd_clear || cmd_enable || cmd_mode;
  assign bad_ch    = !cmd_bcast && (32'(cmd_ch) >= NUM_CH);

  always_comb begin
    target = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      target[i] = cmd_bcast || (32'(cmd_ch) == i);
    end
  end

  // A command with no request bits is a pure no-op, so it never flags o_err
  // even when it names a nonexistent channel.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_d    = clr_q;
    err_d    = 1'b0;
    tgl_en   = '0;
    adv_mode = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && any_req) begin
          if (bad_ch) begin
            err_d = 1'b1;
          end else begin
            tgl_en   = cmd_enable ? target : '0;
            adv_mode = cmd_mode   ? target : '0;
            if (cmd_clear) begin
              state_d = ST_CLR;
              cnt_d   = '0;
              clr_d   = target;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
      end
      ST_CLR: begin
        if (cnt_q == CNT_W'(CLR_CYC - 1)) begin
          state_d = ST_HOLD;
          clr_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        clr_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        clr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    counter_cmd_ch #(.MODE_N(MODE_N)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tgl_en_i   (tgl_en[g]),
      .adv_mode_i (adv_mode[g]),
      .enable_o   (o_enable[g]),
      .mode_o     (o_mode[g*MODE_W +: MODE_W])
    );
  end

  assign o_clear = clr_q;
  assign o_err   = err_q;

endmodule

// File: doc/counter_cmd_ctrl.md
COUNTER_CMD_CTRL -- requirements
Module: counter_cmd_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent counter channels (1..16).
REQ-002 Parameter MODE_N, default 3: number of modes per channel (2..16); MODE_W = max(1, clog2(MODE_N)); CH_W = max(1, clog2(NUM_CH)).
REQ-003 Parameter CLR_CYC, default 2: width of each clear pulse in clk cycles (>=1).
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered this cycle.
REQ-007 cmd_ready  out  1  unit can accept a command; high only in IDLE.
REQ-008 cmd_ch  in  CH_W  target channel index.
REQ-009 cmd_bcast  in  1  apply command to all channels; cmd_ch ignored.
REQ-010 cmd_clear  in  1  request clear pulse.
REQ-011 cmd_enable  in  1  request enable toggle.
REQ-012 cmd_mode  in  1  request mode advance.
REQ-013 o_enable  out  NUM_CH  per-channel run enable.
REQ-014 o_mode  out  NUM_CH*MODE_W  per-channel mode; channel i occupies bits [i*MODE_W +: MODE_W].
REQ-015 o_clear  out  NUM_CH  per-channel clear pulse.
REQ-016 o_err  out  1  one-cycle pulse on a rejected command.

Function
REQ-017 Accept = cmd_valid && cmd_ready at a rising edge; effects are registered and visible from the next cycle (latency 1).
REQ-018 FSM states: IDLE, CLR, HOLD.
REQ-019 IDLE: on accept with cmd_clear=1 go to CLR; on accept with cmd_clear=0 and any other request bit set go to HOLD; otherwise stay.
REQ-020 CLR: o_clear of the targeted channels high for exactly CLR_CYC cycles, then go to HOLD.
REQ-021 HOLD: lasts one cycle, deasserts all o_clear, returns to IDLE; cmd_ready low throughout CLR and HOLD.
REQ-022 cmd_enable toggles o_enable of each targeted channel.
REQ-023 cmd_mode advances the targeted mode by 1, wrapping MODE_N-1 to 0; values >= MODE_N never appear.
REQ-024 Any combination of the three request bits in one command is applied together in the same cycle.
REQ-025 Clear does not alter o_enable or o_mode.
REQ-026 cmd_ch >= NUM_CH with cmd_bcast=0: no state change, o_err high for one cycle, FSM stays IDLE, cmd_ready stays high.
REQ-027 cmd_valid with all request bits 0: accepted as a no-op, no o_err, FSM stays IDLE.
REQ-028 cmd_valid while cmd_ready=0: ignored; the issuer must hold or re-issue.
REQ-029 Non-targeted channels keep all outputs unchanged.

Reset
REQ-030 rst clears o_enable, o_mode, o_clear and o_err to 0 and forces the FSM to IDLE, including mid-CLR, where o_clear drops immediately.
REQ-031 cmd_ready is high in the first cycle after rst deasserts.

Structure
REQ-032 Shared package counter_cmd_pkg holds the FSM state enum (IDLE/CLR/HOLD) and the MODE_W/CH_W derivation functions.
REQ-033 Per-channel enable/mode registers live in sub-module counter_cmd_ch, instantiated NUM_CH times by generate.
REQ-034 The top level holds the FSM, the clear-width counter, the channel decode and o_err.

Verification
REQ-035 Default params: reset, then cmd_ch=2, cmd_enable -> o_enable=4'b0100 next cycle; repeat the command -> 4'b0000.
REQ-036 cmd_mode to ch1 issued 3 times -> o_mode ch1 goes 1, 2, 0 (wrap); other channels stay 0.
REQ-037 cmd_bcast with cmd_clear and cmd_enable -> o_clear=4'b1111 for exactly 2 cycles, o_enable=4'b1111, cmd_ready low for 3 cycles.
REQ-038 NUM_CH=3, cmd_ch=3 -> o_err one-cycle pulse, no output change, cmd_ready stays 1.
REQ-039 rst asserted in the 2nd CLR cycle -> all outputs 0 asynchronously; cmd_ready=1 in the first cycle after release.
REQ-040 cmd_valid held high during CLR with a different command -> ignored; it is accepted in the first IDLE cycle only.
